// File: rtl/v_red_seq_pkg.sv
// Shared vector reduction types: funct6 reduction opcodes, vsew encoding, FSM states,
// and per-(op, sew) helpers for masks and reduction identities.
package v_red_seq_pkg;

  localparam int unsigned RED_W = 32;

  typedef enum logic [5:0] {
    VREDSUM  = 6'b000000,
    VREDAND  = 6'b000001,
    VREDOR   = 6'b000010,
    VREDXOR  = 6'b000011,
    VREDMINU = 6'b000100,
    VREDMIN  = 6'b000101,
    VREDMAXU = 6'b000110,
    VREDMAX  = 6'b000111
  } funct6_red_e;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } vsew_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } red_state_e;

  typedef struct packed {
    logic [5:0] op;
    logic [1:0] sew;
  } red_cfg_t;

  function automatic logic [RED_W-1:0] sew_mask(input logic [1:0] sew);
    case (sew)
      VSEW_8:  return 32'h0000_00FF;
      VSEW_16: return 32'h0000_FFFF;
      VSEW_32: return 32'hFFFF_FFFF;
      default: return '0;
    endcase
  endfunction

  function automatic logic [RED_W-1:0] sew_sign(input logic [1:0] sew);
    case (sew)
      VSEW_8:  return 32'h0000_0080;
      VSEW_16: return 32'h0000_8000;
      VSEW_32: return 32'h8000_0000;
      default: return '0;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return op[5:3] == 3'b000;
  endfunction

  function automatic logic sew_legal(input logic [1:0] sew);
    return sew != VSEW_INVALID;
  endfunction

  // Value that leaves the accumulator unchanged for the given op at SEW bits
  function automatic logic [RED_W-1:0] red_identity(input logic [5:0] op, input logic [1:0] sew);
    case (op)
      VREDAND, VREDMINU: return sew_mask(sew);
      VREDMIN:           return sew_mask(sew) ^ sew_sign(sew);
      VREDMAX:           return sew_sign(sew);
      default:           return '0;
    endcase
  endfunction

endpackage

// File: rtl/v_red_seq_op.sv
// Combinational two-operand reduction step at SEW bits; operands arrive already SEW-masked.
module v_red_op
  import v_red_seq_pkg::*;
#(
  parameter int unsigned ELEN = 32
) (
  input  logic [ELEN-1:0] i_a,
  input  logic [ELEN-1:0] i_b,
  input  logic [5:0]      i_op,
  input  logic [1:0]      i_sew,
  output logic [ELEN-1:0] o_res_c
);

  logic [ELEN-1:0] w_mask;
  logic [ELEN-1:0] w_sign;
  logic [ELEN-1:0] w_sum;
  logic            w_ltu;
  logic            w_lts;

  assign w_mask = ELEN'(sew_mask(i_sew));
  assign w_sign = ELEN'(sew_sign(i_sew));
  assign w_sum  = (i_a + i_b) & w_mask;
  assign w_ltu  = i_a < i_b;
  // Flipping the SEW sign bit turns a signed compare into an unsigned one
  assign w_lts  = (i_a ^ w_sign) < (i_b ^ w_sign);

  always_comb begin
    o_res_c = '0;
    case (i_op)
      VREDSUM:  o_res_c = w_sum;
      VREDAND:  o_res_c = i_a & i_b;
      VREDOR:   o_res_c = i_a | i_b;
      VREDXOR:  o_res_c = i_a ^ i_b;
      VREDMINU: o_res_c = w_ltu ? i_a : i_b;
      VREDMIN:  o_res_c = w_lts ? i_a : i_b;
      VREDMAXU: o_res_c = w_ltu ? i_b : i_a;
      VREDMAX:  o_res_c = w_lts ? i_b : i_a;
      default:  o_res_c = '0;
    endcase
  end

endmodule

// File: rtl/v_red_seq.sv
// Multi-lane sequential RVV integer reduction (vs1[0] seed, vs2 beats -> vd[0] scalar).
// Optional V_RED_MASK_EN adds the elem_mask port for per-slot masking.
module v_red_seq
  import v_red_seq_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ELEN   = 32,
  parameter int unsigned MAX_VL = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [5:0]                  cmd_funct6,
  input  logic [1:0]                  cmd_vsew,
  input  logic [$clog2(MAX_VL+1)-1:0] cmd_vl,
  input  logic [ELEN-1:0]             cmd_seed,
  input  logic                        elem_valid,
  output logic                        elem_ready,
  input  logic [LANES*ELEN-1:0]       elem_data,
`ifdef V_RED_MASK_EN
  input  logic [LANES-1:0]            elem_mask,
`endif
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [ELEN-1:0]             res_data,
  output logic                        res_err
);

  localparam int unsigned VLW  = $clog2(MAX_VL + 1);
  localparam int unsigned TREE = 8;

  red_state_e      r_state;
  red_state_e      w_state_nxt;
  red_cfg_t        r_cfg;
  red_cfg_t        w_cfg_nxt;
  logic [ELEN-1:0] r_acc;
  logic [ELEN-1:0] w_acc_nxt;
  logic [VLW-1:0]  r_rem;
  logic [VLW-1:0]  w_rem_nxt;
  logic [ELEN-1:0] w_res_data_nxt;
  logic            w_res_err_nxt;

  logic [ELEN-1:0]  w_smask;
  logic [ELEN-1:0]  w_ident;
  logic [ELEN-1:0]  w_seed_t;
  logic [LANES-1:0] w_en;
  logic [LANES-1:0] w_act;
  logic [ELEN-1:0]  w_lane [TREE];
  logic [ELEN-1:0]  w_l1 [4];
  logic [ELEN-1:0]  w_l2 [2];
  logic [ELEN-1:0]  w_l3;
  logic [ELEN-1:0]  w_comb;

  assign w_smask  = ELEN'(sew_mask(r_cfg.sew));
  assign w_ident  = ELEN'(red_identity(r_cfg.op, r_cfg.sew));
  assign w_seed_t = cmd_seed & ELEN'(sew_mask(cmd_vsew));

`ifdef V_RED_MASK_EN
  assign w_en = elem_mask;
`else
  assign w_en = '1;
`endif

  // Slot selection: inactive slots and pad lanes feed the identity into the tree
  for (genvar i = 0; i < TREE; i++) begin : g_lane
    if (i < LANES) begin : g_used
      assign w_act[i]  = w_en[i] && (32'(r_rem) > 32'(i));
      assign w_lane[i] = w_act[i] ? (elem_data[i*ELEN +: ELEN] & w_smask) : w_ident;
    end else begin : g_pad
      assign w_lane[i] = w_ident;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_l1
    v_red_op #(.ELEN(ELEN)) u_op (
      .i_a(w_lane[2*k]), .i_b(w_lane[2*k+1]), .i_op(r_cfg.op), .i_sew(r_cfg.sew), .o_res_c(w_l1[k])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_l2
    v_red_op #(.ELEN(ELEN)) u_op (
      .i_a(w_l1[2*k]), .i_b(w_l1[2*k+1]), .i_op(r_cfg.op), .i_sew(r_cfg.sew), .o_res_c(w_l2[k])
    );
  end

  v_red_op #(.ELEN(ELEN)) u_l3 (
    .i_a(w_l2[0]), .i_b(w_l2[1]), .i_op(r_cfg.op), .i_sew(r_cfg.sew), .o_res_c(w_l3)
  );

  v_red_op #(.ELEN(ELEN)) u_acc (
    .i_a(r_acc), .i_b(w_l3), .i_op(r_cfg.op), .i_sew(r_cfg.sew), .o_res_c(w_comb)
  );

  // Next-state and next-datapath values
  always_comb begin
    w_state_nxt    = r_state;
    w_cfg_nxt      = r_cfg;
    w_acc_nxt      = r_acc;
    w_rem_nxt      = r_rem;
    w_res_data_nxt = res_data;
    w_res_err_nxt  = res_err;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_cfg_nxt.op  = cmd_funct6;
          w_cfg_nxt.sew = cmd_vsew;
          w_rem_nxt     = cmd_vl;
          w_acc_nxt     = w_seed_t;
          if (!op_legal(cmd_funct6) || !sew_legal(cmd_vsew)) begin
            w_state_nxt    = DONE;
            w_res_err_nxt  = 1'b1;
            w_res_data_nxt = '0;
          end else if (cmd_vl == '0) begin
            w_state_nxt    = DONE;
            w_res_err_nxt  = 1'b0;
            w_res_data_nxt = w_seed_t;
          end else begin
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (elem_valid) begin
          w_acc_nxt = w_comb;
          if (r_rem <= VLW'(LANES)) begin
            w_rem_nxt      = '0;
            w_state_nxt    = DONE;
            w_res_err_nxt  = 1'b0;
            w_res_data_nxt = w_comb;
          end else begin
            w_rem_nxt = r_rem - VLW'(LANES);
          end
        end
      end
      DONE: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      cmd_ready  <= 1'b1;
      elem_ready <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg      <= w_cfg_nxt;
      r_acc      <= w_acc_nxt;
      r_rem      <= w_rem_nxt;
      cmd_ready  <= (w_state_nxt == IDLE);
      elem_ready <= (w_state_nxt == ACCUM);
      res_valid  <= (w_state_nxt == DONE);
      res_data   <= w_res_data_nxt;
      res_err    <= w_res_err_nxt;
    end
  end

endmodule

// File: tb/tb_v_red_seq.sv
// Directed self-checking bench for v_red_seq (LANES=4, ELEN=32); mask cases under V_RED_MASK_EN.
module tb_v_red_seq;
  import v_red_seq_pkg::*;

  localparam int unsigned LANES  = 4;
  localparam int unsigned ELEN   = 32;
  localparam int unsigned MAX_VL = 32;
  localparam int unsigned VLW    = $clog2(MAX_VL + 1);
  localparam logic [31:0] JUNK   = 32'h5A5A_5A00;

  logic                   clk;
  logic                   nrst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [5:0]             cmd_funct6;
  logic [1:0]             cmd_vsew;
  logic [VLW-1:0]         cmd_vl;
  logic [ELEN-1:0]        cmd_seed;
  logic                   elem_valid;
  logic                   elem_ready;
  logic [LANES*ELEN-1:0]  elem_data;
  logic [LANES-1:0]       elem_mask;
  logic                   res_valid;
  logic                   res_ready;
  logic [ELEN-1:0]        res_data;
  logic                   res_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] elems [8];

  v_red_seq #(.LANES(LANES), .ELEN(ELEN), .MAX_VL(MAX_VL)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct6(cmd_funct6),
    .cmd_vsew(cmd_vsew), .cmd_vl(cmd_vl), .cmd_seed(cmd_seed),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_data(elem_data),
`ifdef V_RED_MASK_EN
    .elem_mask(elem_mask),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_cmd(input logic [5:0] op, input logic [1:0] sew, input int vl,
                        input logic [31:0] seed, output bit ok);
    int n = 0;
    cmd_funct6 = op; cmd_vsew = sew; cmd_vl = VLW'(vl); cmd_seed = seed; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
    ok = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*ELEN-1:0] d, output bit ok);
    int n = 0;
    elem_data = d; elem_valid = 1'b1;
    while (!elem_ready && n < 20) begin @(posedge clk); #1; n++; end
    ok = elem_ready;
    @(posedge clk); #1;
    elem_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat, output bit ok);
    lat = 0;
    while (!res_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    ok = res_valid;
  endtask

  // Full transaction from the elems table; slots at or beyond vl carry JUNK
  task automatic run_red(input logic [5:0] op, input logic [1:0] sew, input int vl,
                         input logic [31:0] seed, input int nbeats,
                         output logic [31:0] data, output logic err, output int lat, output bit ok);
    bit okc;
    logic [LANES*ELEN-1:0] beat;
    do_cmd(op, sew, vl, seed, okc);
    ok = okc;
    for (int b = 0; b < nbeats; b++) begin
      for (int s = 0; s < int'(LANES); s++)
        beat[s*ELEN +: ELEN] = (b*LANES + s < vl) ? elems[b*LANES + s] : JUNK;
      send_beat(beat, okc);
      ok = ok && okc;
    end
    wait_res(lat, okc);
    ok = ok && okc;
    data = res_data; err = res_err;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; cmd_valid = 1'b0; elem_valid = 1'b0; res_ready = 1'b0;
    cmd_funct6 = '0; cmd_vsew = '0; cmd_vl = '0; cmd_seed = '0; elem_data = '0; elem_mask = '1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (elem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_elem_ready: got %b want 0", elem_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %b want 0", res_err); end
    nrst = 1'b1;
  endtask

  task automatic test_sum32();
    bit ok1, ok2, ok3;
    do_cmd(VREDSUM, VSEW_32, 6, 32'd10, ok1);
    n_checks++; if ({ok1, elem_ready, cmd_ready} !== 3'b110) begin n_fail++; $display("FAIL sum32_accum_entry: got ok/er/cr=%b%b%b want 110", ok1, elem_ready, cmd_ready); end
    send_beat({32'd4, 32'd3, 32'd2, 32'd1}, ok2);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL sum32_early_valid: got %b want 0", res_valid); end
    send_beat({JUNK, JUNK, 32'd6, 32'd5}, ok3);
    n_checks++; if ({ok2, ok3, res_valid} !== 3'b111) begin n_fail++; $display("FAIL sum32_valid_timing: got %b%b%b want 111", ok2, ok3, res_valid); end
    n_checks++; if (res_data !== 32'd31) begin n_fail++; $display("FAIL sum32_data: got %0d want 31", res_data); end
    n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL sum32_err: got %b want 0", res_err); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++; if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL sum32_release: got rv/cr=%b%b want 01", res_valid, cmd_ready); end
  endtask

  task automatic test_sum8_wrap();
    logic [31:0] d; logic e; int lat; bit ok;
    for (int i = 0; i < 4; i++) elems[i] = 32'hABCD_0010;
    run_red(VREDSUM, VSEW_8, 4, 32'h1234_56F0, 1, d, e, lat, ok);
    n_checks++; if (d !== 32'h0000_0030) begin n_fail++; $display("FAIL sum8_wrap_data: got %h want 00000030", d); end
    n_checks++; if ({ok, e, lat == 0} !== 3'b101) begin n_fail++; $display("FAIL sum8_wrap_flags: got ok/err=%b%b lat=%0d want 1 0 0", ok, e, lat); end
  endtask

  task automatic test_max_signed_unsigned();
    logic [31:0] d; logic e; int lat; bit ok;
    elems[0] = 32'h0000_8000; elems[1] = 32'h0000_0001;
    run_red(VREDMAX, VSEW_16, 2, 32'h0, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h0000_0001}) begin n_fail++; $display("FAIL max16_signed: got %h ok=%b err=%b want 00000001", d, ok, e); end
    run_red(VREDMAXU, VSEW_16, 2, 32'h0, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h0000_8000}) begin n_fail++; $display("FAIL max16_unsigned: got %h ok=%b err=%b want 00008000", d, ok, e); end
  endtask

  task automatic test_vl0();
    bit ok;
    do_cmd(VREDMIN, VSEW_16, 0, 32'hABCD_1234, ok);
    n_checks++; if ({ok, elem_ready, res_valid, res_err} !== 4'b1010) begin n_fail++; $display("FAIL vl0_flags: got ok/er/rv/err=%b%b%b%b want 1010", ok, elem_ready, res_valid, res_err); end
    n_checks++; if (res_data !== 32'h0000_1234) begin n_fail++; $display("FAIL vl0_data: got %h want 00001234", res_data); end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic e; int lat; bit ok;
    do_cmd(VREDSUM, VSEW_INVALID, 4, 32'hFFFF_FFFF, ok);
    elem_valid = 1'b1; elem_data = {4{JUNK}};
    n_checks++; if ({ok, elem_ready, res_valid, res_err, res_data} !== {4'b1011, 32'h0}) begin n_fail++; $display("FAIL bad_vsew: got er/rv/err=%b%b%b data=%h want 011 0", elem_ready, res_valid, res_err, res_data); end
    cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if ({cmd_ready, elem_ready, res_valid, res_err, res_data} !== {4'b0011, 32'h0}) begin n_fail++; $display("FAIL hold_stable_%0d: got cr/er/rv/err=%b%b%b%b data=%h want 0011 0", c, cmd_ready, elem_ready, res_valid, res_err, res_data); end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; cmd_valid = 1'b0; elem_valid = 1'b0;
    n_checks++; if ({res_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL no_overlap: got rv/cr=%b%b want 01", res_valid, cmd_ready); end
    run_red(6'b010000, VSEW_32, 4, 32'h55, 0, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b11, 32'h0}) begin n_fail++; $display("FAIL bad_funct6: got %h ok=%b err=%b want 0 err 1", d, ok, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat; bit ok;
    do_cmd(VREDSUM, VSEW_32, 10, 32'd7, ok);
    send_beat({32'd1, 32'd1, 32'd1, 32'd1}, ok);
    elem_valid = 1'b1; elem_data = {4{32'd9}}; nrst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({cmd_ready, elem_ready, res_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_reset: got cr/er/rv=%b%b%b want 100", cmd_ready, elem_ready, res_valid); end
    nrst = 1'b1; elem_valid = 1'b0;
    elems[0] = 32'hF; elems[1] = 32'h3;
    run_red(VREDXOR, VSEW_32, 2, 32'h0, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h0000_000C}) begin n_fail++; $display("FAIL xor_after_reset: got %h ok=%b err=%b want 0000000c", d, ok, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat; bit ok;
    elems[0] = 32'hF3; elems[1] = 32'h3F; elems[2] = 32'h7E;
    run_red(VREDAND, VSEW_8, 3, 32'hFF, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h32}) begin n_fail++; $display("FAIL and8: got %h ok=%b err=%b want 00000032", d, ok, e); end
    elems[0] = 32'h1; elems[1] = 32'h10; elems[2] = 32'h1000;
    run_red(VREDOR, VSEW_16, 3, 32'h0100, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h1111}) begin n_fail++; $display("FAIL or16: got %h ok=%b err=%b want 00001111", d, ok, e); end
    elems[0] = 32'h90; elems[1] = 32'h20; elems[2] = 32'h7F; elems[3] = 32'hFF; elems[4] = 32'h05;
    run_red(VREDMINU, VSEW_8, 5, 32'h80, 2, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h05}) begin n_fail++; $display("FAIL minu8: got %h ok=%b err=%b want 00000005", d, ok, e); end
    elems[0] = 32'h80; elems[1] = 32'h7F;
    run_red(VREDMIN, VSEW_8, 2, 32'h10, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'h80}) begin n_fail++; $display("FAIL min8: got %h ok=%b err=%b want 00000080", d, ok, e); end
    for (int i = 0; i < 7; i++) elems[i] = 32'(1 << i);
    run_red(VREDXOR, VSEW_16, 7, 32'hFFFF, 2, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'hFF80}) begin n_fail++; $display("FAIL xor16: got %h ok=%b err=%b want 0000ff80", d, ok, e); end
    elems[0] = 32'hFFFF_FFFF; elems[1] = 32'hFFFF_FFFE; elems[2] = 32'h8000_0001; elems[3] = 32'hFFFF_FFF0;
    run_red(VREDMAX, VSEW_32, 4, 32'h8000_0000, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL max32: got %h ok=%b err=%b want ffffffff", d, ok, e); end
  endtask

`ifdef V_RED_MASK_EN
  task automatic test_mask();
    logic [31:0] d; logic e; int lat; bit ok;
    elems[0] = 32'd1; elems[1] = 32'd2; elems[2] = 32'd3; elems[3] = 32'd4;
    elem_mask = 4'b0101;
    run_red(VREDSUM, VSEW_32, 4, 32'h0, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'd4}) begin n_fail++; $display("FAIL mask_sum: got %h ok=%b err=%b want 00000004", d, ok, e); end
    elem_mask = 4'b0000;
    run_red(VREDSUM, VSEW_32, 4, 32'd9, 1, d, e, lat, ok);
    n_checks++; if ({ok, e, d} !== {2'b10, 32'd9}) begin n_fail++; $display("FAIL mask_all_off: got %h ok=%b err=%b want 00000009", d, ok, e); end
    elem_mask = '1;
  endtask
`endif

  initial begin
    test_reset();
    test_sum32();
    test_sum8_wrap();
    test_max_signed_unsigned();
    test_vl0();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef V_RED_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
